// File: rtl/stream_mux_n.sv
// N-to-1 registered stream multiplexer with valid/ready on every channel.
// Fixed-select or round-robin arbitration feeds a single output beat register.
module stream_mux_n #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk1,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic                r_valid;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_chan;
  logic [SEL_W-1:0]    r_rr_ptr;

  logic                w_load_en;
  logic                w_granted;
  logic [SEL_W-1:0]    w_grant;
  logic [WIDTH-1:0]    w_data;
  logic [SEL_W-1:0]    w_rr_next;
  logic [CHANNELS-1:0] w_ready;

  assign w_load_en = !r_valid || out_ready;

  // Round-robin: first pass covers rr_ptr..CHANNELS-1, second pass wraps to the lowest index.
  always_comb begin
    w_granted = 1'b0;
    w_grant   = '0;
    if (mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!w_granted && in_valid[i] && (i >= int'(r_rr_ptr))) begin
          w_granted = 1'b1;
          w_grant   = SEL_W'(i);
        end
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (!w_granted && in_valid[i]) begin
          w_granted = 1'b1;
          w_grant   = SEL_W'(i);
        end
      end
    end else begin
      // An out-of-range sel matches no channel, so nothing is granted.
      for (int i = 0; i < CHANNELS; i++) begin
        if ((sel == SEL_W'(i)) && in_valid[i]) begin
          w_granted = 1'b1;
          w_grant   = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_rr_next = (w_grant == SEL_W'(CHANNELS - 1)) ? '0 : w_grant + SEL_W'(1);

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_ready[i] = w_load_en && w_granted && (w_grant == SEL_W'(i)) && !reset;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_chan   <= '0;
      r_rr_ptr <= '0;
    end else if (w_load_en) begin
      if (w_granted) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_chan  <= w_grant;
        if (mode) begin
          r_rr_ptr <= w_rr_next;
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_ready;
  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux_n.sv
// Scoreboard bench for stream_mux_n: directed stimulus queues expected beats,
// a negedge monitor pops and compares every beat the consumer takes.
module tb_stream_mux_n;

  logic        clk1 = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        mode;
  logic [3:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pushed = 0;
  int          n_popped = 0;
  logic [5:0]  exp_q[$];
  logic [5:0]  mon_e;

  stream_mux_n #(
    .WIDTH   (4),
    .CHANNELS(4)
  ) dut (
    .clk1     (clk1),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .mode     (mode),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic [3:0] d);
    exp_q.push_back({ch, d});
    n_pushed++;
  endtask

  // Check in_ready mid-cycle, then advance to just past the next rising edge.
  task automatic step(input logic [3:0] exp_rdy, input string nm);
    @(negedge clk1);
    chk(nm, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk1);
    #1;
  endtask

  always @(negedge clk1) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_popped++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_beat: got chan %0d data %0h expected none", out_chan, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_chan", 32'(out_chan), 32'(mon_e[5:4]));
        chk("beat_data", 32'(out_data), 32'(mon_e[3:0]));
      end
    end
  end

  initial begin
    in_data   = {4'hF, 4'h1, 4'hA, 4'h8};
    reset     = 1'b1;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'hF;
    out_ready = 1'b1;

    // Reset held for two edges with all channels valid.
    @(posedge clk1);
    @(negedge clk1);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_chan", 32'(out_chan), 32'h0);
    @(posedge clk1);
    #1;
    reset = 1'b0;

    // Fixed select, sel 0..3 one per cycle.
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      case (i)
        0: push(2'd0, 4'h8);
        1: push(2'd1, 4'hA);
        2: push(2'd2, 4'h1);
        default: push(2'd3, 4'hF);
      endcase
      step(4'(1 << i), "fixed_rdy");
    end

    // Round-robin, all valid: 0,1,2,3,0.
    mode = 1'b1;
    push(2'd0, 4'h8); step(4'b0001, "rr_rdy0");
    push(2'd1, 4'hA); step(4'b0010, "rr_rdy1");
    push(2'd2, 4'h1); step(4'b0100, "rr_rdy2");
    push(2'd3, 4'hF); step(4'b1000, "rr_rdy3");
    push(2'd0, 4'h8); step(4'b0001, "rr_rdy_wrap");

    // Only ch1 valid.
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      push(2'd1, 4'hA);
      step(4'b0010, "rr_ch1_rdy");
    end

    // Stall with the ch1 beat held.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, "stall_rdy");
      chk("stall_valid", 32'(out_valid), 32'h1);
      chk("stall_data", 32'(out_data), 32'hA);
      chk("stall_chan", 32'(out_chan), 32'h1);
    end
    out_ready = 1'b1;
    push(2'd1, 4'hA); step(4'b0010, "release_rdy");

    // Bring rr_ptr to 3, then wrap to ch0 and go on to ch2.
    in_valid = 4'b0100;
    push(2'd2, 4'h1); step(4'b0100, "ptr3_rdy");
    in_valid = 4'b0101;
    push(2'd0, 4'h8); step(4'b0001, "wrap_rdy_ch0");
    push(2'd2, 4'h1); step(4'b0100, "wrap_rdy_ch2");
    in_valid = 4'b0000;
    step(4'b0000, "drain_rdy");

    // Hold a ch1 beat under backpressure, then reset over it.
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    step(4'b0010, "hold_load_rdy");
    in_valid = 4'b0000;
    step(4'b0000, "hold_rdy");
    chk("hold_valid", 32'(out_valid), 32'h1);
    chk("hold_data", 32'(out_data), 32'hA);
    reset = 1'b1;
    step(4'b0000, "reset_mid_rdy");
    chk("reset_mid_valid", 32'(out_valid), 32'h0);
    chk("reset_mid_data", 32'(out_data), 32'h0);
    chk("reset_mid_chan", 32'(out_chan), 32'h0);
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    push(2'd0, 4'h8); step(4'b0001, "post_reset_rr_rdy");
    in_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, "idle_rdy");
    end

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    chk("beat_count", 32'(n_popped), 32'(n_pushed));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
